eth_sma_master_ctrl: RTL and testbench

SMA (MDIO/MDC) master protocol engine that sequences the SMA data buffer.
- Pops 23-bit command words from the tx fifo and serialises IEEE 802.3 clause-22 management frames on MDC/MDIO.
- On reads, pushes the returned 16-bit data into the rx fifo.
- Sits between the SMA data buffer and the pad-level MDIO tristate.

---
 rtl/eth_sma_pkg.sv | 44 ++++
 rtl/eth_sma_mdc_gen.sv | 38 +++
 rtl/eth_sma_master_ctrl.sv | 152 +++++++++++++++
 tb/tb_eth_sma_master_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_sma_pkg.sv
// rtl/eth_sma_pkg.sv - shared types and frame constants for the SMA master
package eth_sma_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_PRE,
        S_ST,
        S_OP,
        S_PHY,
        S_REG,
        S_TA,
        S_DATA,
        S_WB,
        S_DONE
    } sma_state_e;

    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] ST    = 2'b01;
    localparam logic [1:0] TA_WR = 2'b10;

    localparam int CMD_W    = 23;
    localparam int OP_MSB   = 22;
    localparam int OP_LSB   = 21;
    localparam int REG_MSB  = 20;
    localparam int REG_LSB  = 16;
    localparam int DATA_MSB = 15;
    localparam int DATA_LSB = 0;
    localparam int DATA_W   = 16;
    localparam int FRAME_W  = 32;

    // Bit count minus one of each post-preamble field.
    function automatic logic [4:0] field_last(sma_state_e s);
        case (s)
            S_ST, S_OP, S_TA: return 5'd1;
            S_PHY, S_REG:     return 5'd4;
            S_DATA:           return 5'd15;
            default:          return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/eth_sma_mdc_gen.sv
// rtl/eth_sma_mdc_gen.sv - MDC divider with bit-boundary strobes
module eth_sma_mdc_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             sma_mdc,
    output logic             fall_stb,
    output logic             rise_last_stb
);

    logic [DIV_W-1:0] cnt;
    logic             term;

    assign term = (cnt == div);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt     <= '0;
            sma_mdc <= 1'b0;
        end else if (!en) begin
            cnt     <= '0;
            sma_mdc <= 1'b0;
        end else if (term) begin
            cnt     <= '0;
            sma_mdc <= ~sma_mdc;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Last clk of the high phase: read sample point, and MDC falls on this edge.
    assign rise_last_stb = en && sma_mdc && term;
    assign fall_stb      = en && sma_mdc && term;

endmodule

// File: rtl/eth_sma_master_ctrl.sv
// rtl/eth_sma_master_ctrl.sv - clause-22 SMA master frame engine
module eth_sma_master_ctrl
    import eth_sma_pkg::*;
#(
    parameter int PRE_LEN = 32,
    parameter int DIV_W   = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              r_sma_en,
    input  logic              r_preamble_en,
    input  logic [4:0]        r_phy_addr,
    input  logic [DIV_W-1:0]  r_clk_div,
    input  logic              tx_fifo_empty,
    input  logic [22:0]       tx_fifo_rdata,
    output logic              tx_fifo_re,
    input  logic              rx_fifo_full,
    output logic              rx_fifo_we,
    output logic [15:0]       rx_fifo_wdata,
    output logic              sma_mdc,
    output logic              sma_mdio_o,
    output logic              sma_mdio_oe,
    input  logic              sma_mdio_i,
    output logic              busy,
    output logic              int_status_trans_done,
    output logic              int_status_cmd_err
);

    sma_state_e          state, state_n;
    logic [CMD_W-1:0]    cmd_q;
    logic [DIV_W-1:0]    div_q;
    logic [FRAME_W-1:0]  tx_sr;
    logic [FRAME_W-1:0]  frame_word;
    logic [4:0]          bit_cnt;
    logic [DATA_W-1:0]   rx_sr;
    logic [1:0]          mdio_sync;
    logic                armed;
    logic [1:0]          op;
    logic                op_legal, is_rd, mdc_en, fall_stb, rise_last_stb, field_end, oe_n;

    assign op         = cmd_q[OP_MSB:OP_LSB];
    assign op_legal   = (op == OP_WR) || (op == OP_RD);
    assign is_rd      = (op == OP_RD);
    assign field_end  = fall_stb && (bit_cnt == 5'd0);
    assign mdc_en     = state inside {S_PRE, S_ST, S_OP, S_PHY, S_REG, S_TA, S_DATA};
    // Read frames leave TA and data undriven; zeros keep sma_mdio_o quiet there.
    assign frame_word = {ST, op, r_phy_addr, cmd_q[REG_MSB:REG_LSB],
                         is_rd ? 18'd0 : {TA_WR, cmd_q[DATA_MSB:DATA_LSB]}};
    assign oe_n       = (state_n inside {S_PRE, S_ST, S_OP, S_PHY, S_REG, S_TA, S_DATA}) &&
                        !(is_rd && (state_n inside {S_TA, S_DATA}));

    assign busy          = tx_fifo_re ||
                           ((state != S_IDLE) && (state != S_DONE) && !int_status_cmd_err);
    assign rx_fifo_wdata = rx_sr;

    eth_sma_mdc_gen #(.DIV_W(DIV_W)) u_mdc_gen (
        .clk           (clk),
        .rstn          (rstn),
        .en            (mdc_en),
        .div           (div_q),
        .sma_mdc       (sma_mdc),
        .fall_stb      (fall_stb),
        .rise_last_stb (rise_last_stb)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n               = state;
        tx_fifo_re            = 1'b0;
        rx_fifo_we            = 1'b0;
        int_status_trans_done = 1'b0;
        int_status_cmd_err    = 1'b0;
        case (state)
            S_IDLE: begin
                if (armed && r_sma_en && !tx_fifo_empty) begin
                    tx_fifo_re = 1'b1;
                    state_n    = S_FETCH;
                end
            end
            S_FETCH:  state_n = S_DECODE;
            S_DECODE: begin
                if (!op_legal) begin
                    int_status_cmd_err = 1'b1;
                    state_n            = S_IDLE;
                end else begin
                    state_n = r_preamble_en ? S_PRE : S_ST;
                end
            end
            S_PRE:  if (field_end) state_n = S_ST;
            S_ST:   if (field_end) state_n = S_OP;
            S_OP:   if (field_end) state_n = S_PHY;
            S_PHY:  if (field_end) state_n = S_REG;
            S_REG:  if (field_end) state_n = S_TA;
            S_TA:   if (field_end) state_n = S_DATA;
            S_DATA: if (field_end) state_n = is_rd ? S_WB : S_DONE;
            S_WB: begin
                if (!rx_fifo_full) begin
                    rx_fifo_we = 1'b1;
                    state_n    = S_DONE;
                end
            end
            S_DONE: begin
                int_status_trans_done = 1'b1;
                state_n               = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            armed       <= 1'b0;
            mdio_sync   <= 2'b00;
            cmd_q       <= '0;
            div_q       <= '0;
            tx_sr       <= '0;
            bit_cnt     <= 5'd0;
            sma_mdio_o  <= 1'b0;
            sma_mdio_oe <= 1'b0;
            rx_sr       <= '0;
        end else begin
            armed     <= 1'b1;
            mdio_sync <= {mdio_sync[0], sma_mdio_i};
            if (state == S_FETCH) cmd_q <= tx_fifo_rdata;
            if (state == S_DECODE && op_legal) begin
                div_q       <= r_clk_div;
                tx_sr       <= frame_word;
                bit_cnt     <= r_preamble_en ? 5'(PRE_LEN - 1) : field_last(S_ST);
                sma_mdio_o  <= r_preamble_en ? 1'b1 : frame_word[FRAME_W-1];
                sma_mdio_oe <= 1'b1;
            end else if (fall_stb) begin
                if (state == S_PRE) begin
                    // Preamble holds ones; the shifter only starts at ST.
                    bit_cnt    <= field_end ? field_last(S_ST) : bit_cnt - 5'd1;
                    sma_mdio_o <= field_end ? tx_sr[FRAME_W-1] : 1'b1;
                end else begin
                    tx_sr      <= tx_sr << 1;
                    bit_cnt    <= field_end ? field_last(state_n) : bit_cnt - 5'd1;
                    sma_mdio_o <= oe_n & tx_sr[FRAME_W-2];
                end
                sma_mdio_oe <= oe_n;
            end
            if (state == S_DATA && is_rd && rise_last_stb)
                rx_sr <= {rx_sr[DATA_W-2:0], mdio_sync[1]};
        end
    end

endmodule

// File: tb/tb_eth_sma_master_ctrl.sv
// tb/tb_eth_sma_master_ctrl.sv - scoreboard bench for eth_sma_master_ctrl
module tb_eth_sma_master_ctrl;

    localparam int DIV_W = 8;
    localparam logic [1:0] K_ERR  = 2'd0;
    localparam logic [1:0] K_RD   = 2'd1;
    localparam logic [1:0] K_DONE = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [63:0] bits;
        logic [63:0] oe;
        logic [7:0]  nbits;
        logic [7:0]  per;
        logic [15:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             r_sma_en = 1'b0;
    logic             r_preamble_en = 1'b1;
    logic [4:0]       r_phy_addr = 5'd0;
    logic [DIV_W-1:0] r_clk_div = '0;
    logic             tx_fifo_empty;
    logic [22:0]      tx_fifo_rdata = '0;
    logic             tx_fifo_re;
    logic             rx_fifo_full = 1'b0;
    logic             rx_fifo_we;
    logic [15:0]      rx_fifo_wdata;
    logic             sma_mdc, sma_mdio_o, sma_mdio_oe;
    logic             sma_mdio_i = 1'b0;
    logic             busy, int_status_trans_done, int_status_cmd_err;

    eth_sma_master_ctrl #(.PRE_LEN(32), .DIV_W(DIV_W)) dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .r_sma_en              (r_sma_en),
        .r_preamble_en         (r_preamble_en),
        .r_phy_addr            (r_phy_addr),
        .r_clk_div             (r_clk_div),
        .tx_fifo_empty         (tx_fifo_empty),
        .tx_fifo_rdata         (tx_fifo_rdata),
        .tx_fifo_re            (tx_fifo_re),
        .rx_fifo_full          (rx_fifo_full),
        .rx_fifo_we            (rx_fifo_we),
        .rx_fifo_wdata         (rx_fifo_wdata),
        .sma_mdc               (sma_mdc),
        .sma_mdio_o            (sma_mdio_o),
        .sma_mdio_oe           (sma_mdio_oe),
        .sma_mdio_i            (sma_mdio_i),
        .busy                  (busy),
        .int_status_trans_done (int_status_trans_done),
        .int_status_cmd_err    (int_status_cmd_err)
    );

    always #5 clk = ~clk;

    // Command fifo model: one-cycle read latency.
    logic [22:0] cmd_mem [0:15];
    int pushes = 0;
    int pops   = 0;
    assign tx_fifo_empty = (pushes == pops);
    always @(posedge clk) begin
        if (tx_fifo_re) begin
            tx_fifo_rdata <= cmd_mem[pops[3:0]];
            pops          <= pops + 1;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    exp_t exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, expv);
    endtask

    task automatic push_cmd(input logic [22:0] c);
        cmd_mem[pushes[3:0]] = c;
        pushes++;
    endtask

    task automatic exp_frame(input logic [63:0] b, input logic [63:0] o, input int n, input int p);
        exp_t e;
        e = '0;
        e.kind = K_DONE; e.bits = b; e.oe = o; e.nbits = 8'(n); e.per = 8'(p);
        exp_q.push_back(e);
    endtask

    task automatic exp_item(input logic [1:0] k, input logic [15:0] d);
        exp_t e;
        e = '0;
        e.kind = k; e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: captures MDIO at each MDC rise, plays the PHY, and scores outputs.
    int cyc = 0, cap_n = 0, fall_n = 0, re_cnt = 0, we_cnt = 0;
    int last_re_cyc = 0, err_cyc = -100, last_rise = -1, min_per = 999, max_per = 0;
    int data_start = 48;
    logic [63:0] cap_bits = '0, cap_oe = '0;
    logic        prev_mdc = 1'b0;
    logic [15:0] phy_data = '0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (tx_fifo_re) begin
            re_cnt++; last_re_cyc = cyc;
            cap_n = 0; cap_bits = '0; cap_oe = '0; fall_n = 0;
            last_rise = -1; min_per = 999; max_per = 0;
        end
        if (sma_mdc && !prev_mdc) begin
            cap_bits = {cap_bits[62:0], sma_mdio_o};
            cap_oe   = {cap_oe[62:0], sma_mdio_oe};
            cap_n++;
            if (last_rise >= 0) begin
                if (cyc - last_rise < min_per) min_per = cyc - last_rise;
                if (cyc - last_rise > max_per) max_per = cyc - last_rise;
            end
            last_rise = cyc;
        end
        if (!sma_mdc && prev_mdc) begin
            fall_n++;
            if (fall_n >= data_start && fall_n < data_start + 16)
                sma_mdio_i = phy_data[15 - (fall_n - data_start)];
            else
                sma_mdio_i = 1'b0;
        end
        prev_mdc = sma_mdc;
        if (rx_fifo_we) begin
            we_cnt++;
            chk("rd_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rd_kind", e.kind, K_RD);
                chk("rd_data", rx_fifo_wdata, e.data);
            end
        end
        if (int_status_cmd_err) begin
            err_cyc = cyc;
            chk("err_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("err_kind", e.kind, K_ERR);
                chk("err_no_mdc", cap_n, 0);
            end
        end
        if (int_status_trans_done) begin
            chk("done_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("done_kind", e.kind, K_DONE);
                chk("frame_len", cap_n, e.nbits);
                chk("frame_bits", cap_bits, e.bits);
                chk("frame_oe", cap_oe, e.oe);
                chk("mdc_period_min", min_per, e.per);
                chk("mdc_period_max", max_per, e.per);
                chk("busy_at_done", busy, 0);
            end
        end
    end

    task automatic drain(input string nm, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(nm, exp_q.size(), 0);
    endtask

    task automatic idle_outputs(input string nm);
        chk(nm, {sma_mdc, sma_mdio_o, sma_mdio_oe, busy, tx_fifo_re, rx_fifo_we,
                 int_status_trans_done, int_status_cmd_err, rx_fifo_wdata}, 0);
    endtask

    initial begin
        int re0, we0, n;

        repeat (3) @(negedge clk);
        idle_outputs("reset_state");
        @(posedge clk); #2;
        rstn = 1'b1;

        // 1: write with preamble, div 1
        r_clk_div = 8'd1; r_phy_addr = 5'h01; r_preamble_en = 1'b1; r_sma_en = 1'b1;
        re0 = re_cnt;
        exp_frame(64'hFFFFFFFF_5092A5C3, 64'hFFFFFFFF_FFFFFFFF, 64, 4);
        push_cmd({2'b01, 5'h04, 16'hA5C3});
        drain("t1_drain", 600);
        chk("t1_pops", re_cnt - re0, 1);

        // 2: read returning 7941
        @(posedge clk); #2;
        r_phy_addr = 5'h1F; phy_data = 16'h7941;
        exp_item(K_RD, 16'h7941);
        exp_frame(64'hFFFFFFFF_6F880000, 64'hFFFFFFFF_FFFC0000, 64, 4);
        push_cmd({2'b10, 5'h02, 16'h0000});
        drain("t2_drain", 600);

        // 3: read stalled in WB by a full rx fifo
        @(posedge clk); #2;
        rx_fifo_full = 1'b1; phy_data = 16'hBEEF;
        re0 = re_cnt; we0 = we_cnt;
        exp_item(K_RD, 16'hBEEF);
        exp_frame(64'hFFFFFFFF_6F880000, 64'hFFFFFFFF_FFFC0000, 64, 4);
        push_cmd({2'b10, 5'h02, 16'h0000});
        n = 0;
        while (!(re_cnt > re0 && cap_n == 64) && n < 600) begin @(posedge clk); n++; end
        chk("t3_frame_seen", cap_n, 64);
        repeat (50) @(posedge clk);
        chk("t3_busy_stall", busy, 1);
        chk("t3_no_we_while_full", we_cnt - we0, 0);
        #2 rx_fifo_full = 1'b0;
        @(negedge clk);
        chk("t3_we_after_release", rx_fifo_we, 1);
        drain("t3_drain", 100);

        // 4: illegal op then a write with no preamble
        @(posedge clk); #2;
        r_preamble_en = 1'b0; r_phy_addr = 5'h01;
        re0 = re_cnt;
        exp_item(K_ERR, 16'h0);
        exp_frame(64'h00000000_508E1234, 64'h00000000_FFFFFFFF, 32, 4);
        push_cmd({2'b11, 5'h03, 16'h1234});
        push_cmd({2'b01, 5'h03, 16'h1234});
        drain("t4_drain", 600);
        chk("t4_pops", re_cnt - re0, 2);
        chk("t4_refetch_gap", last_re_cyc - err_cyc, 1);

        // 5: div 0, enable dropped mid-frame
        @(posedge clk); #2;
        r_clk_div = 8'd0; r_phy_addr = 5'h12;
        re0 = re_cnt;
        exp_frame(64'h00000000_596A3C5A, 64'h00000000_FFFFFFFF, 32, 2);
        push_cmd({2'b01, 5'h1A, 16'h3C5A});
        push_cmd({2'b01, 5'h07, 16'h0F0F});
        n = 0;
        while (re_cnt == re0 && n < 100) begin @(posedge clk); n++; end
        repeat (10) @(posedge clk);
        #2 r_sma_en = 1'b0;
        drain("t5_drain", 300);
        repeat (20) @(posedge clk);
        chk("t5_no_refetch", re_cnt - re0, 1);
        chk("t5_idle", busy, 0);

        // 6: reset at bit 20 of the queued write, then a clean fetch
        @(posedge clk); #2;
        r_clk_div = 8'd1; r_phy_addr = 5'h01; r_preamble_en = 1'b1;
        re0 = re_cnt;
        push_cmd({2'b01, 5'h09, 16'h8001});
        r_sma_en = 1'b1;
        n = 0;
        while (!(re_cnt > re0 && cap_n >= 20) && n < 400) begin @(posedge clk); n++; end
        chk("t6_busy_before_reset", busy, 1);
        #2 rstn = 1'b0;
        #1 idle_outputs("t6_async_reset");
        repeat (3) @(posedge clk);
        #2;
        exp_frame(64'hFFFFFFFF_50A68001, 64'hFFFFFFFF_FFFFFFFF, 64, 4);
        rstn = 1'b1;
        drain("t6_drain", 600);
        chk("t6_pops", re_cnt - re0, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
